// File: rtl/hls_scratchpad_slave_if.sv
// Bundle of ap_fifo streams between the bus-to-FIFO bridge (master) and the scratchpad responder (slave).
// Four per-field command FIFOs feed the slave; two response FIFOs are pushed by it.
interface hls_scratchpad_slave_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
);
  logic [DATA_ADDR_WIDTH-1:0] io_bus_cmd_payload_address_V_dout;
  logic                       io_bus_cmd_payload_address_V_empty_n;
  logic                       io_bus_cmd_payload_address_V_read;
  logic [DATA_WIDTH-1:0]      io_bus_cmd_payload_data_V_dout;
  logic                       io_bus_cmd_payload_data_V_empty_n;
  logic                       io_bus_cmd_payload_data_V_read;
  logic [DATA_WIDTH/8-1:0]    io_bus_cmd_payload_mask_V_dout;
  logic                       io_bus_cmd_payload_mask_V_empty_n;
  logic                       io_bus_cmd_payload_mask_V_read;
  logic                       io_bus_cmd_payload_write_V_dout;
  logic                       io_bus_cmd_payload_write_V_empty_n;
  logic                       io_bus_cmd_payload_write_V_read;
  logic [DATA_WIDTH-1:0]      io_bus_rsp_payload_data_V_din;
  logic                       io_bus_rsp_payload_data_V_full_n;
  logic                       io_bus_rsp_payload_data_V_write;
  logic                       io_bus_rsp_valid_V_din;
  logic                       io_bus_rsp_valid_V_full_n;
  logic                       io_bus_rsp_valid_V_write;

  modport slave (
    input  io_bus_cmd_payload_address_V_dout, io_bus_cmd_payload_address_V_empty_n,
    output io_bus_cmd_payload_address_V_read,
    input  io_bus_cmd_payload_data_V_dout, io_bus_cmd_payload_data_V_empty_n,
    output io_bus_cmd_payload_data_V_read,
    input  io_bus_cmd_payload_mask_V_dout, io_bus_cmd_payload_mask_V_empty_n,
    output io_bus_cmd_payload_mask_V_read,
    input  io_bus_cmd_payload_write_V_dout, io_bus_cmd_payload_write_V_empty_n,
    output io_bus_cmd_payload_write_V_read,
    output io_bus_rsp_payload_data_V_din, io_bus_rsp_payload_data_V_write,
    input  io_bus_rsp_payload_data_V_full_n,
    output io_bus_rsp_valid_V_din, io_bus_rsp_valid_V_write,
    input  io_bus_rsp_valid_V_full_n
  );

  modport master (
    output io_bus_cmd_payload_address_V_dout, io_bus_cmd_payload_address_V_empty_n,
    input  io_bus_cmd_payload_address_V_read,
    output io_bus_cmd_payload_data_V_dout, io_bus_cmd_payload_data_V_empty_n,
    input  io_bus_cmd_payload_data_V_read,
    output io_bus_cmd_payload_mask_V_dout, io_bus_cmd_payload_mask_V_empty_n,
    input  io_bus_cmd_payload_mask_V_read,
    output io_bus_cmd_payload_write_V_dout, io_bus_cmd_payload_write_V_empty_n,
    input  io_bus_cmd_payload_write_V_read,
    input  io_bus_rsp_payload_data_V_din, io_bus_rsp_payload_data_V_write,
    output io_bus_rsp_payload_data_V_full_n,
    input  io_bus_rsp_valid_V_din, io_bus_rsp_valid_V_write,
    output io_bus_rsp_valid_V_full_n
  );
endinterface

// File: rtl/hls_scratchpad_slave.sv
// Scratchpad responder: pops one command from the four cmd FIFOs, executes it on a local RAM,
// and pushes a response for reads. One command in flight at a time.
module hls_scratchpad_slave #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DATA_ADDR_WIDTH = 32,
  parameter int                    DEPTH           = 256,
  parameter logic [DATA_ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA        = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hls_scratchpad_slave_if.slave bus,
  output logic [15:0]          err_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int MW = DATA_WIDTH / 8;
  localparam logic [DATA_ADDR_WIDTH-1:0] WIN_MASK = DATA_ADDR_WIDTH'(DEPTH * 4 - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                     state;
  logic                       armed;
  logic [DATA_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [MW-1:0]              mask_q;
  logic                       write_q;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_valid;
  logic [DATA_WIDTH-1:0]      ram [DEPTH];

  logic          cmd_avail;
  logic          pop;
  logic          push;
  logic          hit;
  logic [IW-1:0] idx;

  assign cmd_avail = bus.io_bus_cmd_payload_address_V_empty_n & bus.io_bus_cmd_payload_data_V_empty_n
                   & bus.io_bus_cmd_payload_mask_V_empty_n & bus.io_bus_cmd_payload_write_V_empty_n;
  // Strobes derive from state only, so an async reset clears them without waiting for a clock.
  assign pop  = armed && (state == IDLE) && cmd_avail;
  assign push = (state == RESP) && bus.io_bus_rsp_payload_data_V_full_n && bus.io_bus_rsp_valid_V_full_n;
  assign hit  = (addr_q & ~WIN_MASK) == BASE_ADDR;
  assign idx  = addr_q[2 +: IW];

  assign bus.io_bus_cmd_payload_address_V_read = pop;
  assign bus.io_bus_cmd_payload_data_V_read    = pop;
  assign bus.io_bus_cmd_payload_mask_V_read    = pop;
  assign bus.io_bus_cmd_payload_write_V_read   = pop;
  assign bus.io_bus_rsp_payload_data_V_write   = push;
  assign bus.io_bus_rsp_valid_V_write          = push;
  assign bus.io_bus_rsp_payload_data_V_din     = rsp_data;
  assign bus.io_bus_rsp_valid_V_din            = rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      err_count <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            addr_q  <= bus.io_bus_cmd_payload_address_V_dout;
            data_q  <= bus.io_bus_cmd_payload_data_V_dout;
            mask_q  <= bus.io_bus_cmd_payload_mask_V_dout;
            write_q <= bus.io_bus_cmd_payload_write_V_dout;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (!hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (write_q) begin
            state <= IDLE;
          end else begin
            rsp_data  <= hit ? ram[idx] : ERR_DATA;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == EXEC && write_q && hit) begin
      for (int b = 0; b < MW; b++) begin
        if (mask_q[b]) ram[idx][8*b +: 8] <= data_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_hls_scratchpad_slave.sv
// Directed bench for the scratchpad responder: drives the cmd FIFO heads directly and
// watches the pop/push strobes against hand-computed expectations.
module tb_hls_scratchpad_slave;
  logic clk;
  logic rst_n;
  logic [15:0] err_count;

  hls_scratchpad_slave_if #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) bus ();

  hls_scratchpad_slave #(
    .DATA_WIDTH(32), .DATA_ADDR_WIDTH(32), .DEPTH(256),
    .BASE_ADDR(32'h0), .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int partial_err = 0;

  // Observes every cycle for split pops/pushes and tallies transfers.
  always @(negedge clk) begin
    if (!(bus.io_bus_cmd_payload_address_V_read == bus.io_bus_cmd_payload_data_V_read &&
          bus.io_bus_cmd_payload_address_V_read == bus.io_bus_cmd_payload_mask_V_read &&
          bus.io_bus_cmd_payload_address_V_read == bus.io_bus_cmd_payload_write_V_read))
      partial_err++;
    if (bus.io_bus_rsp_payload_data_V_write != bus.io_bus_rsp_valid_V_write) partial_err++;
    if (bus.io_bus_rsp_payload_data_V_write) push_cnt++;
    if (bus.io_bus_cmd_payload_address_V_read) pop_cnt++;
  end

  task automatic set_empty_n(input logic a, input logic d, input logic m, input logic w);
    bus.io_bus_cmd_payload_address_V_empty_n = a;
    bus.io_bus_cmd_payload_data_V_empty_n    = d;
    bus.io_bus_cmd_payload_mask_V_empty_n    = m;
    bus.io_bus_cmd_payload_write_V_empty_n   = w;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic w);
    bus.io_bus_cmd_payload_address_V_dout = a;
    bus.io_bus_cmd_payload_data_V_dout    = d;
    bus.io_bus_cmd_payload_mask_V_dout    = m;
    bus.io_bus_cmd_payload_write_V_dout   = w;
    set_empty_n(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  // Presents a command and waits (bounded) for the pop; returns cycles waited, 0 on timeout.
  task automatic issue_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input logic w, output int waited);
    present(a, d, m, w);
    waited = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.io_bus_cmd_payload_address_V_read) begin
        waited = i;
        break;
      end
    end
    n_cmp++;
    if (waited == 0) begin
      n_bad++;
      $display("FAIL pop_timeout addr=%h: got no pop, required pop within 30 cycles", a);
    end else begin
      @(posedge clk);
      #1;
    end
    set_empty_n(1'b0, 1'b0, 1'b0, 1'b0);
    $display("cmd  %s addr=%h data=%h mask=%h popped after %0d cycle(s)", w ? "WR" : "RD", a, d, m, waited);
  endtask

  // Waits (bounded) for a response push and checks its contents.
  task automatic expect_rsp(input logic [31:0] exp, output int waited);
    waited = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.io_bus_rsp_payload_data_V_write) begin
        waited = i;
        break;
      end
    end
    n_cmp++;
    if (waited == 0) begin
      n_bad++;
      $display("FAIL rsp_timeout: got no push, required push within 30 cycles");
    end else begin
      n_cmp++;
      if (bus.io_bus_rsp_payload_data_V_din !== exp) begin
        n_bad++;
        $display("FAIL rsp_data: got %h required %h", bus.io_bus_rsp_payload_data_V_din, exp);
      end
      n_cmp++;
      if (bus.io_bus_rsp_valid_V_din !== 1'b1 || bus.io_bus_rsp_valid_V_write !== 1'b1) begin
        n_bad++;
        $display("FAIL rsp_valid: got din=%b write=%b required 1/1",
                 bus.io_bus_rsp_valid_V_din, bus.io_bus_rsp_valid_V_write);
      end
      $display("rsp  data=%h after %0d cycle(s)", bus.io_bus_rsp_payload_data_V_din, waited);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    present(32'h100, 32'h1, 4'hF, 1'b0);
    bus.io_bus_rsp_payload_data_V_full_n = 1'b1;
    bus.io_bus_rsp_valid_V_full_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.io_bus_cmd_payload_address_V_read !== 1'b0 || bus.io_bus_rsp_payload_data_V_write !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got read=%b write=%b required 0/0",
               bus.io_bus_cmd_payload_address_V_read, bus.io_bus_rsp_payload_data_V_write);
    end
    n_cmp++;
    if (err_count !== 16'd0 || bus.io_bus_rsp_payload_data_V_din !== 32'd0 || bus.io_bus_rsp_valid_V_din !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs: got err=%h din=%h vdin=%b required 0/0/0",
               err_count, bus.io_bus_rsp_payload_data_V_din, bus.io_bus_rsp_valid_V_din);
    end
    set_empty_n(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_write_read();
    int w;
    int base;
    issue_cmd(32'h100, 32'hA5A5A5A5, 4'hF, 1'b1, w);
    base = push_cnt;
    issue_cmd(32'h100, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'hA5A5A5A5, w);
    n_cmp++;
    if (w !== 2) begin
      n_bad++;
      $display("FAIL read_latency: got %0d cycles after pop, required 2", w);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (push_cnt - base !== 1) begin
      n_bad++;
      $display("FAIL single_push: got %0d pushes required 1", push_cnt - base);
    end
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL err_count_wr_rd: got %0d required 0", err_count);
    end
  endtask

  task automatic test_mask();
    int w;
    issue_cmd(32'h104, 32'h11223344, 4'hF, 1'b1, w);
    issue_cmd(32'h104, 32'hAABBCCDD, 4'h5, 1'b1, w);
    issue_cmd(32'h104, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'h11BB33DD, w);
  endtask

  task automatic test_back_to_back();
    int w;
    issue_cmd(32'h10C, 32'hCAFEF00D, 4'hF, 1'b1, w);
    issue_cmd(32'h110, 32'h12345678, 4'hF, 1'b1, w);
    n_cmp++;
    if (w !== 2) begin
      n_bad++;
      $display("FAIL b2b_pop_gap: got %0d cycles required 2", w);
    end
    issue_cmd(32'h10C, 32'h0, 4'h0, 1'b0, w);
    n_cmp++;
    if (w !== 2) begin
      n_bad++;
      $display("FAIL b2b_read_gap: got %0d cycles required 2", w);
    end
    expect_rsp(32'hCAFEF00D, w);
    issue_cmd(32'h110, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'h12345678, w);
  endtask

  task automatic test_backpressure();
    int w;
    int bad_push = 0;
    int bad_din = 0;
    int base_pop;
    bus.io_bus_rsp_payload_data_V_full_n = 1'b0;
    issue_cmd(32'h100, 32'h0, 4'h0, 1'b0, w);
    present(32'h108, 32'h01020304, 4'hF, 1'b1);
    base_pop = pop_cnt;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.io_bus_rsp_payload_data_V_write || bus.io_bus_rsp_valid_V_write) bad_push++;
      if (bus.io_bus_rsp_payload_data_V_din !== 32'hA5A5A5A5) bad_din++;
    end
    @(posedge clk);
    #1;
    bus.io_bus_rsp_payload_data_V_full_n = 1'b1;
    bus.io_bus_rsp_valid_V_full_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.io_bus_rsp_payload_data_V_write || bus.io_bus_rsp_valid_V_write) bad_push++;
    end
    n_cmp++;
    if (bad_push !== 0) begin
      n_bad++;
      $display("FAIL bp_no_push: got %0d pushing cycles required 0", bad_push);
    end
    n_cmp++;
    if (bad_din !== 0) begin
      n_bad++;
      $display("FAIL bp_din_stable: got %0d unstable cycles required 0", bad_din);
    end
    n_cmp++;
    if (pop_cnt !== base_pop) begin
      n_bad++;
      $display("FAIL bp_no_pop: got %0d pops required 0", pop_cnt - base_pop);
    end
    @(posedge clk);
    #1 bus.io_bus_rsp_valid_V_full_n = 1'b1;
    expect_rsp(32'hA5A5A5A5, w);
    n_cmp++;
    if (w !== 1) begin
      n_bad++;
      $display("FAIL bp_release: got push after %0d cycles required 1", w);
    end
    issue_cmd(32'h108, 32'h01020304, 4'hF, 1'b1, w);
    issue_cmd(32'h108, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'h01020304, w);
  endtask

  task automatic test_partial();
    int w;
    int base_pop;
    present(32'h104, 32'h0, 4'h0, 1'b0);
    set_empty_n(1'b1, 1'b1, 1'b1, 1'b0);
    base_pop = pop_cnt;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (pop_cnt !== base_pop) begin
      n_bad++;
      $display("FAIL partial_no_pop: got %0d pops required 0", pop_cnt - base_pop);
    end
    @(posedge clk);
    #1;
    issue_cmd(32'h104, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'h11BB33DD, w);
  endtask

  task automatic test_out_of_window();
    int w;
    issue_cmd(32'h400, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'hDEADBEEF, w);
    n_cmp++;
    if (err_count !== 16'd1) begin
      n_bad++;
      $display("FAIL oob_read_err: got %0d required 1", err_count);
    end
    issue_cmd(32'h500, 32'h0, 4'hF, 1'b1, w);
    issue_cmd(32'h100, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'hA5A5A5A5, w);
    n_cmp++;
    if (err_count !== 16'd2) begin
      n_bad++;
      $display("FAIL oob_write_err: got %0d required 2", err_count);
    end
  endtask

  task automatic test_reset_in_resp();
    int w;
    int base;
    issue_cmd(32'h100, 32'h0, 4'h0, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.io_bus_rsp_payload_data_V_write !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_push: got write=%b required 1", bus.io_bus_rsp_payload_data_V_write);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.io_bus_rsp_payload_data_V_write !== 1'b0 || bus.io_bus_rsp_valid_V_write !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_strobe_drop: got %b/%b required 0/0",
               bus.io_bus_rsp_payload_data_V_write, bus.io_bus_rsp_valid_V_write);
    end
    base = push_cnt;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_err_clear: got %0d required 0", err_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (push_cnt !== base) begin
      n_bad++;
      $display("FAIL rst_stale_push: got %0d pushes required 0", push_cnt - base);
    end
    @(posedge clk);
    #1;
    issue_cmd(32'h104, 32'h0, 4'h0, 1'b0, w);
    expect_rsp(32'h11BB33DD, w);
    n_cmp++;
    if (partial_err !== 0) begin
      n_bad++;
      $display("FAIL split_strobes: got %0d split cycles required 0", partial_err);
    end
  endtask

  initial begin
    set_empty_n(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_partial();
    test_out_of_window();
    test_reset_in_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
